// File: rtl/cube_frame_sequencer.sv
// cube_frame_sequencer: per-frame clear, edge-draw and buffer-swap controller for the rotating-cube renderer.
module cube_frame_sequencer #(
  parameter int SIZE       = 10,
  parameter int NUM_EDGES  = 12,
  parameter int COORD_W    = 16,
  parameter int ADDR_W     = 8,
  parameter int ANGLE_STEP = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      frame_tick,
  output logic [3:0]                edge_idx,
  input  logic signed [COORD_W-1:0] edge_x0,
  input  logic signed [COORD_W-1:0] edge_y0,
  input  logic signed [COORD_W-1:0] edge_x1,
  input  logic signed [COORD_W-1:0] edge_y1,
  output logic [COORD_W-1:0]        line_x0,
  output logic [COORD_W-1:0]        line_y0,
  output logic [COORD_W-1:0]        line_x1,
  output logic [COORD_W-1:0]        line_y1,
  output logic                      line_start,
  input  logic                      line_busy,
  input  logic                      line_done,
  output logic                      clr_we,
  output logic [ADDR_W-1:0]         clr_addr,
  output logic                      draw_buf,
  output logic [8:0]                angle,
  output logic                      frame_ready,
  output logic                      overrun
);
  localparam int CELLS = (SIZE + 1) * (SIZE + 1);
  typedef enum logic [2:0] {IDLE, CLEAR, LOAD, START, WAIT, READY} state_t;
  state_t state_q, state_d;
  logic [3:0] edge_idx_q, edge_idx_d;
  logic [3:0][COORD_W-1:0] line_q, line_d;
  logic line_start_q, line_start_d, clr_we_q, clr_we_d;
  logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
  logic draw_buf_q, draw_buf_d, frame_ready_q, frame_ready_d, overrun_q, overrun_d;
  logic [8:0] angle_q, angle_d;
  function automatic logic [COORD_W-1:0] clamp(input logic signed [COORD_W-1:0] v);
    return v[COORD_W-1] ? '0 : (v > $signed(COORD_W'(SIZE)) ? COORD_W'(SIZE) : v);
  endfunction
  always_comb begin
    state_d       = state_q;
    edge_idx_d    = edge_idx_q;
    line_d        = line_q;
    line_start_d  = 1'b0;
    clr_we_d      = clr_we_q;
    clr_addr_d    = clr_addr_q;
    draw_buf_d    = draw_buf_q;
    angle_d       = angle_q;
    frame_ready_d = frame_ready_q;
    overrun_d     = overrun_q | (frame_tick && state_q != IDLE && state_q != READY);
    case (state_q)
      IDLE: if (frame_tick) begin
        state_d    = CLEAR;
        clr_we_d   = 1'b1;
        clr_addr_d = '0;
      end
      CLEAR: if (clr_addr_q == ADDR_W'(CELLS - 1)) begin
        state_d    = LOAD;
        clr_we_d   = 1'b0;
        clr_addr_d = '0;
        edge_idx_d = '0;
      end else clr_addr_d = clr_addr_q + ADDR_W'(1);
      LOAD: begin
        line_d  = {clamp(edge_x0), clamp(edge_y0), clamp(edge_x1), clamp(edge_y1)};
        state_d = START;
      end
      START: if (!line_busy) begin
        line_start_d = 1'b1;
        state_d      = WAIT;
      end
      WAIT: if (line_done) begin
        if (edge_idx_q == 4'(NUM_EDGES - 1)) begin
          state_d       = READY;
          frame_ready_d = 1'b1;
        end else begin
          edge_idx_d = edge_idx_q + 4'd1;
          state_d    = LOAD;
        end
      end
      READY: if (frame_tick) begin
        state_d       = CLEAR;
        clr_we_d      = 1'b1;
        clr_addr_d    = '0;
        frame_ready_d = 1'b0;
        draw_buf_d    = ~draw_buf_q;
        // wrap by subtraction first so the sum never exceeds 359
        angle_d       = angle_q >= 9'(360 - ANGLE_STEP) ? angle_q - 9'(360 - ANGLE_STEP)
                                                        : angle_q + 9'(ANGLE_STEP);
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      edge_idx_q    <= '0;
      line_q        <= '0;
      line_start_q  <= 1'b0;
      clr_we_q      <= 1'b0;
      clr_addr_q    <= '0;
      draw_buf_q    <= 1'b0;
      angle_q       <= '0;
      frame_ready_q <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      edge_idx_q    <= edge_idx_d;
      line_q        <= line_d;
      line_start_q  <= line_start_d;
      clr_we_q      <= clr_we_d;
      clr_addr_q    <= clr_addr_d;
      draw_buf_q    <= draw_buf_d;
      angle_q       <= angle_d;
      frame_ready_q <= frame_ready_d;
      overrun_q     <= overrun_d;
    end
  end
  assign edge_idx    = edge_idx_q;
  assign {line_x0, line_y0, line_x1, line_y1} = line_q;
  assign line_start  = line_start_q;
  assign clr_we      = clr_we_q;
  assign clr_addr    = clr_addr_q;
  assign draw_buf    = draw_buf_q;
  assign angle       = angle_q;
  assign frame_ready = frame_ready_q;
  assign overrun     = overrun_q;
endmodule
